// File: rtl/ahb_sram_arb2.sv
// Two-port AHB-lite arbiter in front of a zero-wait-state single-port SRAM slave.
// Optional locked-transfer support is compiled in with `define SRAM_ARB_LOCK_EN.
module ahb_sram_arb2 #(
    parameter int unsigned AW   = 32,
    parameter int unsigned DW   = 64,
    parameter int unsigned PRIO = 0
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          M0_HSEL,
    input  logic          M0_HREADY,
    input  logic [1:0]    M0_HTRANS,
    input  logic          M0_HWRITE,
    input  logic [2:0]    M0_HSIZE,
    input  logic [AW-1:0] M0_HADDR,
    input  logic [DW-1:0] M0_HWDATA,
`ifdef SRAM_ARB_LOCK_EN
    input  logic          M0_HMASTLOCK,
    input  logic          M1_HMASTLOCK,
`endif
    output logic          M0_HREADYOUT,
    output logic [1:0]    M0_HRESP,
    output logic [DW-1:0] M0_HRDATA,
    input  logic          M1_HSEL,
    input  logic          M1_HREADY,
    input  logic [1:0]    M1_HTRANS,
    input  logic          M1_HWRITE,
    input  logic [2:0]    M1_HSIZE,
    input  logic [AW-1:0] M1_HADDR,
    input  logic [DW-1:0] M1_HWDATA,
    output logic          M1_HREADYOUT,
    output logic [1:0]    M1_HRESP,
    output logic [DW-1:0] M1_HRDATA,
    output logic          S_HSEL,
    output logic          S_HREADY,
    output logic [1:0]    S_HTRANS,
    output logic          S_HWRITE,
    output logic [2:0]    S_HSIZE,
    output logic [AW-1:0] S_HADDR,
    output logic [DW-1:0] S_HWDATA,
    input  logic          S_HREADYOUT,
    input  logic [1:0]    S_HRESP,
    input  logic [DW-1:0] S_HRDATA
);
    typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_ISSUE} st_t;

    localparam logic PRIO_ID = (PRIO != 0);

    st_t           st0_q, st1_q, st0_d, st1_d;
    logic [AW-1:0] cap_addr0_q, cap_addr1_q;
    logic          cap_wr0_q, cap_wr1_q;
    logic [2:0]    cap_size0_q, cap_size1_q;
    logic          s_rdy, pend0, pend1, own0, own1, new0, new1;
    logic          elig0, elig1, p0, p1, n0, n1;
    logic          gnt_any, gnt_id, gnt0, gnt1;
    logic          unused_ok;

    assign unused_ok = &{1'b0, M0_HTRANS[0], M1_HTRANS[0]};

    assign s_rdy    = S_HREADYOUT;
    assign S_HREADY = S_HREADYOUT;
    assign pend0    = (st0_q == ST_PEND);
    assign pend1    = (st1_q == ST_PEND);
    assign own0     = (st0_q == ST_ISSUE);
    assign own1     = (st1_q == ST_ISSUE);

    assign M0_HREADYOUT = ~(pend0 | (own0 & ~s_rdy));
    assign M1_HREADYOUT = ~(pend1 | (own1 & ~s_rdy));
    // A request only counts in a cycle where this port is presenting ready.
    assign new0 = M0_HSEL & M0_HREADY & M0_HTRANS[1] & M0_HREADYOUT;
    assign new1 = M1_HSEL & M1_HREADY & M1_HTRANS[1] & M1_HREADYOUT;

`ifdef SRAM_ARB_LOCK_EN
    logic lock_q, lock_id_q, cap_lock0_q, cap_lock1_q, lock_rel, lock_eff, gnt_lock;

    assign lock_rel = lock_q & (lock_id_q ? (M1_HREADY & ~M1_HMASTLOCK)
                                          : (M0_HREADY & ~M0_HMASTLOCK));
    assign lock_eff = lock_q & ~lock_rel;
    assign elig0    = ~(lock_eff & lock_id_q);
    assign elig1    = ~(lock_eff & ~lock_id_q);
    assign gnt_lock = gnt_id ? (pend1 ? cap_lock1_q : M1_HMASTLOCK)
                             : (pend0 ? cap_lock0_q : M0_HMASTLOCK);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            lock_q      <= 1'b0;
            lock_id_q   <= 1'b0;
            cap_lock0_q <= 1'b0;
            cap_lock1_q <= 1'b0;
        end else begin
            if (new0 & ~gnt0) cap_lock0_q <= M0_HMASTLOCK;
            if (new1 & ~gnt1) cap_lock1_q <= M1_HMASTLOCK;
            if (gnt_any & gnt_lock) begin
                lock_q    <= 1'b1;
                lock_id_q <= gnt_id;
            end else if (lock_rel) begin
                lock_q    <= 1'b0;
            end
        end
    end
`else
    assign elig0 = 1'b1;
    assign elig1 = 1'b1;
`endif

    // A pending port beats any new request; ties go to PRIO.
    always_comb begin
        p0 = elig0 & pend0;
        p1 = elig1 & pend1;
        n0 = elig0 & new0;
        n1 = elig1 & new1;
        gnt_id = 1'b0;
        if (p0 | p1) gnt_id = (p0 & p1) ? PRIO_ID : p1;
        else         gnt_id = (n0 & n1) ? PRIO_ID : n1;
        gnt_any = s_rdy & (p0 | p1 | n0 | n1);
    end

    assign gnt0 = gnt_any & ~gnt_id;
    assign gnt1 = gnt_any & gnt_id;

    always_comb begin
        st0_d = st0_q;
        if (gnt0)                             st0_d = ST_ISSUE;
        else if (new0)                        st0_d = ST_PEND;
        else if ((st0_q == ST_ISSUE) && s_rdy) st0_d = ST_IDLE;
        st1_d = st1_q;
        if (gnt1)                             st1_d = ST_ISSUE;
        else if (new1)                        st1_d = ST_PEND;
        else if ((st1_q == ST_ISSUE) && s_rdy) st1_d = ST_IDLE;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            st0_q       <= ST_IDLE;
            st1_q       <= ST_IDLE;
            cap_addr0_q <= '0;
            cap_addr1_q <= '0;
            cap_wr0_q   <= 1'b0;
            cap_wr1_q   <= 1'b0;
            cap_size0_q <= '0;
            cap_size1_q <= '0;
        end else begin
            st0_q <= st0_d;
            st1_q <= st1_d;
            if (new0 & ~gnt0) begin
                cap_addr0_q <= M0_HADDR;
                cap_wr0_q   <= M0_HWRITE;
                cap_size0_q <= M0_HSIZE;
            end
            if (new1 & ~gnt1) begin
                cap_addr1_q <= M1_HADDR;
                cap_wr1_q   <= M1_HWRITE;
                cap_size1_q <= M1_HSIZE;
            end
        end
    end

    always_comb begin
        S_HSEL   = 1'b0;
        S_HTRANS = 2'b00;
        S_HWRITE = 1'b0;
        S_HSIZE  = '0;
        S_HADDR  = '0;
        if (gnt_any) begin
            S_HSEL   = 1'b1;
            S_HTRANS = 2'b10;
            if (gnt_id) begin
                S_HWRITE = pend1 ? cap_wr1_q   : M1_HWRITE;
                S_HSIZE  = pend1 ? cap_size1_q : M1_HSIZE;
                S_HADDR  = pend1 ? cap_addr1_q : M1_HADDR;
            end else begin
                S_HWRITE = pend0 ? cap_wr0_q   : M0_HWRITE;
                S_HSIZE  = pend0 ? cap_size0_q : M0_HSIZE;
                S_HADDR  = pend0 ? cap_addr0_q : M0_HADDR;
            end
        end
    end

    assign S_HWDATA  = own1 ? M1_HWDATA : M0_HWDATA;
    assign M0_HRDATA = own0 ? S_HRDATA : '0;
    assign M1_HRDATA = own1 ? S_HRDATA : '0;
    assign M0_HRESP  = own0 ? S_HRESP  : 2'b00;
    assign M1_HRESP  = own1 ? S_HRESP  : 2'b00;
endmodule

// File: tb/tb_ahb_sram_arb2.sv
// Directed bench for ahb_sram_arb2 with a zero-wait SRAM model whose ready/response can be forced.
module tb_ahb_sram_arb2;
    localparam logic [1:0] NS = 2'b10, SQ = 2'b11, ID = 2'b00;
    localparam logic [63:0] DF = 64'hD000_0000_0000_0000;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        M0_HSEL, M0_HREADY, M0_HWRITE, M0_HREADYOUT;
    logic [1:0]  M0_HTRANS, M0_HRESP;
    logic [2:0]  M0_HSIZE;
    logic [31:0] M0_HADDR;
    logic [63:0] M0_HWDATA, M0_HRDATA;
    logic        M1_HSEL, M1_HREADY, M1_HWRITE, M1_HREADYOUT;
    logic [1:0]  M1_HTRANS, M1_HRESP;
    logic [2:0]  M1_HSIZE;
    logic [31:0] M1_HADDR;
    logic [63:0] M1_HWDATA, M1_HRDATA;
`ifdef SRAM_ARB_LOCK_EN
    logic        M0_HMASTLOCK, M1_HMASTLOCK;
`endif
    logic        S_HSEL, S_HREADY, S_HWRITE, S_HREADYOUT;
    logic [1:0]  S_HTRANS, S_HRESP;
    logic [2:0]  S_HSIZE;
    logic [31:0] S_HADDR;
    logic [63:0] S_HWDATA, S_HRDATA;
    logic        stall, err;

    int nvec = 0, nerr = 0;

    always #5 HCLK = ~HCLK;

    ahb_sram_arb2 #(.AW(32), .DW(64), .PRIO(0)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .M0_HSEL(M0_HSEL), .M0_HREADY(M0_HREADY), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE),
        .M0_HSIZE(M0_HSIZE), .M0_HADDR(M0_HADDR), .M0_HWDATA(M0_HWDATA),
`ifdef SRAM_ARB_LOCK_EN
        .M0_HMASTLOCK(M0_HMASTLOCK), .M1_HMASTLOCK(M1_HMASTLOCK),
`endif
        .M0_HREADYOUT(M0_HREADYOUT), .M0_HRESP(M0_HRESP), .M0_HRDATA(M0_HRDATA),
        .M1_HSEL(M1_HSEL), .M1_HREADY(M1_HREADY), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE),
        .M1_HSIZE(M1_HSIZE), .M1_HADDR(M1_HADDR), .M1_HWDATA(M1_HWDATA),
        .M1_HREADYOUT(M1_HREADYOUT), .M1_HRESP(M1_HRESP), .M1_HRDATA(M1_HRDATA),
        .S_HSEL(S_HSEL), .S_HREADY(S_HREADY), .S_HTRANS(S_HTRANS), .S_HWRITE(S_HWRITE),
        .S_HSIZE(S_HSIZE), .S_HADDR(S_HADDR), .S_HWDATA(S_HWDATA),
        .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP), .S_HRDATA(S_HRDATA)
    );

    // Each master's bus ready is its own port ready.
    assign M0_HREADY   = M0_HREADYOUT;
    assign M1_HREADY   = M1_HREADYOUT;
    assign S_HREADYOUT = ~stall;
    assign S_HRESP     = {1'b0, err};

    // SRAM model: unwritten words read as DF | word index.
    bit [63:0]  mem [0:127];
    bit [127:0] wrt;
    logic       sv, sw;
    logic [6:0] sa;
    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sv <= 1'b0;
            sw <= 1'b0;
            sa <= '0;
        end else if (S_HREADY) begin
            if (sv & sw) begin
                mem[sa] <= S_HWDATA;
                wrt[sa] <= 1'b1;
            end
            sv <= S_HSEL & S_HTRANS[1];
            sw <= S_HWRITE;
            sa <= S_HADDR[9:3];
        end
    end
    assign S_HRDATA = (sv & ~sw) ? (wrt[sa] ? mem[sa] : (DF | 64'(sa))) : '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge HCLK);
        #1;
    endtask

    task automatic m0(input logic [1:0] tr, input logic wr, input logic [31:0] a);
        M0_HSEL = 1'b1; M0_HTRANS = tr; M0_HWRITE = wr; M0_HADDR = a;
    endtask

    task automatic m1(input logic [1:0] tr, input logic wr, input logic [31:0] a);
        M1_HSEL = 1'b1; M1_HTRANS = tr; M1_HWRITE = wr; M1_HADDR = a;
    endtask

    initial begin
        logic        hr_prev, pv, m1done;
        int          pidx, wi, lowcnt;
        logic [63:0] d1;

        HRESETn = 1'b0; stall = 1'b0; err = 1'b0;
        M0_HSEL = 1'b0; M0_HTRANS = ID; M0_HWRITE = 1'b0; M0_HSIZE = 3'd3; M0_HADDR = '0; M0_HWDATA = '0;
        M1_HSEL = 1'b0; M1_HTRANS = ID; M1_HWRITE = 1'b0; M1_HSIZE = 3'd3; M1_HADDR = '0; M1_HWDATA = '0;
`ifdef SRAM_ARB_LOCK_EN
        M0_HMASTLOCK = 1'b0; M1_HMASTLOCK = 1'b0;
`endif
        nxt(); #2;
        chk("rst_s_htrans", 64'(S_HTRANS), 64'd0);
        chk("rst_s_hsel", 64'(S_HSEL), 64'd0);
        chk("rst_rdy0", 64'(M0_HREADYOUT), 64'd1);
        chk("rst_rdy1", 64'(M1_HREADYOUT), 64'd1);
        chk("rst_resp0", 64'(M0_HRESP), 64'd0);
        chk("rst_rdata1", M1_HRDATA, 64'd0);
        nxt(); HRESETn = 1'b1;

        // M0 write then read of word 0x40, uncontested
        nxt(); m0(NS, 1'b1, 32'h40); #2;
        chk("wr_s_addr", 64'(S_HADDR), 64'h40);
        chk("wr_s_htrans", 64'(S_HTRANS), 64'd2);
        chk("wr_s_hwrite", 64'(S_HWRITE), 64'd1);
        nxt(); m0(NS, 1'b0, 32'h40); M0_HWDATA = 64'h1122334455667788; #2;
        chk("wr_rdy0", 64'(M0_HREADYOUT), 64'd1);
        chk("wr_s_hwdata", S_HWDATA, 64'h1122334455667788);
        chk("rd_s_hwrite", 64'(S_HWRITE), 64'd0);
        nxt(); m0(ID, 1'b0, 32'h0); #2;
        chk("rd_rdy0", 64'(M0_HREADYOUT), 64'd1);
        chk("rd_rdata0", M0_HRDATA, 64'h1122334455667788);
        chk("rd_rdata1_nonowner", M1_HRDATA, 64'd0);

        // Simultaneous reads: M0 (PRIO) first, M1 one wait state
        nxt(); m0(NS, 1'b0, 32'h08); m1(NS, 1'b0, 32'h10); #2;
        chk("ct_s_addr0", 64'(S_HADDR), 64'h08);
        chk("ct_rdy0_a", 64'(M0_HREADYOUT), 64'd1);
        nxt(); m0(ID, 1'b0, 32'h0); m1(ID, 1'b0, 32'h0); #2;
        chk("ct_wait1", 64'(M1_HREADYOUT), 64'd0);
        chk("ct_s_addr1", 64'(S_HADDR), 64'h10);
        chk("ct_rdata0", M0_HRDATA, DF | 64'd1);
        chk("ct_rdata1_zero", M1_HRDATA, 64'd0);
        nxt(); #2;
        chk("ct_rdy1", 64'(M1_HREADYOUT), 64'd1);
        chk("ct_rdata1", M1_HRDATA, DF | 64'd2);
        chk("ct_s_idle", 64'(S_HTRANS), 64'd0);

        // Pending M1 beats a new M0 request
        nxt(); m0(NS, 1'b0, 32'h08); m1(NS, 1'b0, 32'h10); #2;
        nxt(); m0(NS, 1'b0, 32'h18); m1(ID, 1'b0, 32'h0); #2;
        chk("pb_s_addr", 64'(S_HADDR), 64'h10);
        chk("pb_rdy0", 64'(M0_HREADYOUT), 64'd1);
        chk("pb_rdy1", 64'(M1_HREADYOUT), 64'd0);
        nxt(); m0(ID, 1'b0, 32'h0); #2;
        chk("pb_wait0", 64'(M0_HREADYOUT), 64'd0);
        chk("pb_s_addr2", 64'(S_HADDR), 64'h18);
        chk("pb_rdata1", M1_HRDATA, DF | 64'd2);
        nxt(); #2;
        chk("pb_rdy0_b", 64'(M0_HREADYOUT), 64'd1);
        chk("pb_rdata0", M0_HRDATA, DF | 64'd3);

        // M0 streams six writes; M1 issues one read in the middle
        hr_prev = 1'b1; pv = 1'b0; pidx = 0; wi = 0; lowcnt = 0; m1done = 1'b0; d1 = '0;
        for (int c = 0; c < 12; c++) begin
            nxt();
            if (hr_prev) begin
                if (pv) M0_HWDATA = 64'hA5A5_0000_0000_0000 | 64'(pidx);
                if (wi < 6) begin
                    m0(NS, 1'b1, 32'h100 + 32'(wi * 8));
                    pv = 1'b1; pidx = wi; wi++;
                end else begin
                    m0(ID, 1'b0, 32'h0);
                    pv = 1'b0;
                end
            end
            if (c == 1) m1(NS, 1'b0, 32'h08);
            else        m1(ID, 1'b0, 32'h0);
            #2;
            if (c >= 2 && !m1done) begin
                if (!M1_HREADYOUT) lowcnt++;
                else begin m1done = 1'b1; d1 = M1_HRDATA; end
            end
            hr_prev = M0_HREADYOUT;
        end
        chk("st_m1_done", 64'(m1done), 64'd1);
        chk("st_m1_waits", 64'(lowcnt), 64'd1);
        chk("st_m1_rdata", d1, DF | 64'd1);
        for (int k = 0; k < 6; k++)
            chk($sformatf("st_mem%0d", k), mem[32 + k], 64'hA5A5_0000_0000_0000 | 64'(k));

        // SRAM stalls 3 cycles during an M1 read; M0 request captured meanwhile
        nxt(); m1(NS, 1'b0, 32'h10); #2;
        chk("sl_s_addr", 64'(S_HADDR), 64'h10);
        nxt(); m1(ID, 1'b0, 32'h0); stall = 1'b1; #2;
        chk("sl_rdy1_a", 64'(M1_HREADYOUT), 64'd0);
        chk("sl_s_idle_a", 64'(S_HTRANS), 64'd0);
        nxt(); m0(NS, 1'b0, 32'h18); #2;
        chk("sl_rdy1_b", 64'(M1_HREADYOUT), 64'd0);
        chk("sl_s_idle_b", 64'(S_HTRANS), 64'd0);
        chk("sl_rdy0_addr", 64'(M0_HREADYOUT), 64'd1);
        nxt(); m0(ID, 1'b0, 32'h0); #2;
        chk("sl_rdy1_c", 64'(M1_HREADYOUT), 64'd0);
        chk("sl_pend0", 64'(M0_HREADYOUT), 64'd0);
        chk("sl_s_idle_c", 64'(S_HTRANS), 64'd0);
        nxt(); stall = 1'b0; #2;
        chk("sl_rdy1_d", 64'(M1_HREADYOUT), 64'd1);
        chk("sl_rdata1", M1_HRDATA, DF | 64'd2);
        chk("sl_s_addr0", 64'(S_HADDR), 64'h18);
        nxt(); #2;
        chk("sl_rdy0_e", 64'(M0_HREADYOUT), 64'd1);
        chk("sl_rdata0", M0_HRDATA, DF | 64'd3);

        // Two-cycle ERROR response passed to the owner only
        nxt(); m0(NS, 1'b0, 32'h08); #2;
        nxt(); m0(ID, 1'b0, 32'h0); err = 1'b1; stall = 1'b1; #2;
        chk("er_resp0_a", 64'(M0_HRESP), 64'd1);
        chk("er_resp1", 64'(M1_HRESP), 64'd0);
        chk("er_rdy0_a", 64'(M0_HREADYOUT), 64'd0);
        nxt(); stall = 1'b0; #2;
        chk("er_resp0_b", 64'(M0_HRESP), 64'd1);
        chk("er_rdy0_b", 64'(M0_HREADYOUT), 64'd1);
        nxt(); err = 1'b0; #2;

        // Reset while M1 is pending drops the transfer
        nxt(); m0(NS, 1'b0, 32'h08); m1(NS, 1'b0, 32'h10); #2;
        nxt(); m0(ID, 1'b0, 32'h0); m1(ID, 1'b0, 32'h0); #1; HRESETn = 1'b0; #1;
        chk("mr_rdy1", 64'(M1_HREADYOUT), 64'd1);
        chk("mr_s_htrans", 64'(S_HTRANS), 64'd0);
        chk("mr_s_hsel", 64'(S_HSEL), 64'd0);
        nxt(); HRESETn = 1'b1;
        nxt(); #2;
        chk("mr_rdy1_after", 64'(M1_HREADYOUT), 64'd1);
        chk("mr_rdata1_after", M1_HRDATA, 64'd0);

`ifdef SRAM_ARB_LOCK_EN
        // Locked 4-beat M0 write holds off an M1 read of the first beat's word
        nxt(); m0(NS, 1'b1, 32'h200); M0_HMASTLOCK = 1'b1; m1(NS, 1'b0, 32'h200); #2;
        chk("lk_s_addr0", 64'(S_HADDR), 64'h200);
        chk("lk_s_hwrite0", 64'(S_HWRITE), 64'd1);
        nxt(); m0(SQ, 1'b1, 32'h208); M0_HWDATA = 64'h0BEE_F000_0000_0000; m1(ID, 1'b0, 32'h0); #2;
        chk("lk_rdy1_b1", 64'(M1_HREADYOUT), 64'd0);
        chk("lk_s_addr1", 64'(S_HADDR), 64'h208);
        nxt(); m0(SQ, 1'b1, 32'h210); M0_HWDATA = 64'h0BEE_F000_0000_0001; #2;
        chk("lk_rdy1_b2", 64'(M1_HREADYOUT), 64'd0);
        chk("lk_s_addr2", 64'(S_HADDR), 64'h210);
        nxt(); m0(SQ, 1'b1, 32'h218); M0_HWDATA = 64'h0BEE_F000_0000_0002; #2;
        chk("lk_rdy1_b3", 64'(M1_HREADYOUT), 64'd0);
        chk("lk_s_addr3", 64'(S_HADDR), 64'h218);
        nxt(); m0(ID, 1'b0, 32'h0); M0_HMASTLOCK = 1'b0; M0_HWDATA = 64'h0BEE_F000_0000_0003; #2;
        chk("lk_rdy1_b4", 64'(M1_HREADYOUT), 64'd0);
        chk("lk_s_addr_m1", 64'(S_HADDR), 64'h200);
        chk("lk_s_hwrite_m1", 64'(S_HWRITE), 64'd0);
        nxt(); #2;
        chk("lk_rdy1_done", 64'(M1_HREADYOUT), 64'd1);
        chk("lk_rdata1", M1_HRDATA, 64'h0BEE_F000_0000_0000);
`endif

        nxt();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
